// File: rtl/pd_sequencer.sv
// Packet decoder sequencer: loads header/target bytes, then steps the hash core over nonces.
// Optional hash watchdog enabled by defining PD_TIMEOUT_EN.
module pd_sequencer #(
  parameter int          HDR_BYTES   = 76,
  parameter int          TGT_BYTES   = 32,
  parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable,
  input  logic [7:0]  rx_data,
  input  logic [7:0]  byte_cnt,
  input  logic        packet_done,
  input  logic        hash_done,
  input  logic        valid_hash,
  input  logic        abort,
  output logic        hdr_we,
  output logic [6:0]  hdr_addr,
  output logic        tgt_we,
  output logic [4:0]  tgt_addr,
  output logic [7:0]  wr_data,
  output logic        start_hash,
  output logic [31:0] nonce,
  output logic        busy,
  output logic        found,
  output logic        exhausted,
  output logic        pkt_err,
  output logic        hash_err
);

  // state     | meaning
  // IDLE      | waiting for byte 0 of a packet
  // LOAD      | steering packet bytes into header/target files
  // START     | start_hash pulse for current nonce
  // WAIT_HASH | hash core running
  // FOUND     | valid hash, nonce holds winner
  // EXHAUSTED | NONCE_LAST failed
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HASH, FOUND, EXHAUSTED} state_t;

  localparam logic [7:0] HDR_LEN = 8'(HDR_BYTES);
  localparam logic [7:0] PKT_LEN = 8'(HDR_BYTES + TGT_BYTES);

  state_t     state;
  logic [7:0] count;
  logic       err;
  logic       byte_ok;
  logic       byte_bad;
  logic [7:0] count_next;
  logic       err_next;

`ifdef PD_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmr;
`else
  assign hash_err = 1'b0;
`endif

  // Length check on packet_done must include a byte arriving in the same cycle.
  always_comb begin
    byte_ok    = write_enable && (byte_cnt == count) && (byte_cnt < PKT_LEN);
    byte_bad   = write_enable && !byte_ok;
    count_next = count + 8'(byte_ok);
    err_next   = err | byte_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      err        <= 1'b0;
      hdr_we     <= 1'b0;
      hdr_addr   <= '0;
      tgt_we     <= 1'b0;
      tgt_addr   <= '0;
      wr_data    <= '0;
      start_hash <= 1'b0;
      nonce      <= '0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      pkt_err    <= 1'b0;
`ifdef PD_TIMEOUT_EN
      hash_err   <= 1'b0;
      tmr        <= '0;
`endif
    end else begin
      hdr_we     <= 1'b0;
      tgt_we     <= 1'b0;
      start_hash <= 1'b0;
      pkt_err    <= 1'b0;
`ifdef PD_TIMEOUT_EN
      hash_err   <= 1'b0;
`endif
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        found     <= 1'b0;
        exhausted <= 1'b0;
        err       <= 1'b0;
        count     <= '0;
      end else begin
        case (state)
          IDLE, FOUND, EXHAUSTED: begin
            if (write_enable && byte_cnt == 8'd0) begin
              found     <= 1'b0;
              exhausted <= 1'b0;
              nonce     <= '0;
              err       <= 1'b0;
              hdr_we    <= 1'b1;
              hdr_addr  <= '0;
              wr_data   <= rx_data;
              if (packet_done) begin
                pkt_err <= 1'b1;
                count   <= '0;
                state   <= IDLE;
              end else begin
                count <= 8'd1;
                state <= LOAD;
              end
            end
          end
          LOAD: begin
            if (byte_ok) begin
              wr_data <= rx_data;
              if (byte_cnt < HDR_LEN) begin
                hdr_we   <= 1'b1;
                hdr_addr <= byte_cnt[6:0];
              end else begin
                tgt_we   <= 1'b1;
                tgt_addr <= 5'(byte_cnt - HDR_LEN);
              end
            end
            count <= count_next;
            err   <= err_next;
            if (packet_done) begin
              count <= '0;
              err   <= 1'b0;
              if (count_next == PKT_LEN && !err_next) begin
                state      <= START;
                start_hash <= 1'b1;
                busy       <= 1'b1;
              end else begin
                pkt_err <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          START: begin
            state <= WAIT_HASH;
            if (packet_done) pkt_err <= 1'b1;
`ifdef PD_TIMEOUT_EN
            tmr <= TMR_LOAD;
`endif
          end
          WAIT_HASH: begin
            if (packet_done) pkt_err <= 1'b1;
            if (hash_done) begin
              if (valid_hash) begin
                state <= FOUND;
                found <= 1'b1;
                busy  <= 1'b0;
              end else if (nonce == NONCE_LAST) begin
                state     <= EXHAUSTED;
                exhausted <= 1'b1;
                busy      <= 1'b0;
              end else begin
                nonce      <= nonce + 32'd1;
                state      <= START;
                start_hash <= 1'b1;
              end
            end
`ifdef PD_TIMEOUT_EN
            else if (tmr == '0) begin
              hash_err <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              tmr <= tmr - TW'(1);
            end
`endif
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
